regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: write data width.
REQ-002 The block SHALL have parameter ADR_WIDTH, default 5: register address width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports alu_valid, alu_ready (output), alu_addr [ADR_WIDTH], alu_data [DATA_WIDTH]: ALU writeback requester.
REQ-006 The block SHALL have ports ld_valid, ld_ready (output), ld_addr [ADR_WIDTH], ld_data [DATA_WIDTH]: load-unit writeback requester.
REQ-007 The block SHALL have outputs we3 (1 bit), a3 [ADR_WIDTH] and wd3 [DATA_WIDTH]: the single register-file write port.
REQ-008 The block SHALL have output busy, 1 bit: any buffered entry or registered write is pending.

Function
REQ-009 Each requester SHALL own a one-entry holding buffer; a transfer occurs on a cycle when valid and ready are both high.
REQ-010 ready SHALL be high when that buffer is empty, or when it is full and is granted in the same cycle (full-throughput pass-through).
REQ-011 Each cycle, at most one full buffer SHALL be granted; the grant drains the buffer and loads we3/a3/wd3 at the next edge.
REQ-012 we3/a3/wd3 SHALL be registered; a transfer accepted at edge T SHALL drive we3=1 no earlier than the cycle after edge T+1, giving 2-cycle minimum latency.
REQ-013 With no grant, we3 SHALL be 0; a3/wd3 SHALL hold their last values.
REQ-014 A transfer with addr==0 SHALL be accepted and discarded; it SHALL NOT occupy the buffer or assert we3.
REQ-015 Default arbitration SHALL be fixed priority: ld wins over alu when both buffers are full.
REQ-016 If both requesters target the same nonzero address and are pending together, both writes SHALL issue in grant order; the later grant's data is final.
REQ-017 Data in a buffer SHALL NOT change while that buffer is full and ungranted.
REQ-018 busy SHALL be the OR of both buffer-full flags and the registered we3.

Reset
REQ-019 While rst is high at an edge, both buffers SHALL become empty and we3=0, a3=0, wd3=0; any in-flight entry SHALL be lost.
REQ-020 alu_ready and ld_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.
REQ-021 The round-robin pointer (when compiled in) SHALL reset to favour alu.

Configuration
REQ-022 With macro WB_RR_ARB_EN defined, arbitration SHALL be round-robin: after a contested grant, the other requester has priority on the next contest; uncontested grants SHALL NOT move the pointer.
REQ-023 Without WB_RR_ARB_EN, arbitration SHALL be fixed priority per REQ-015, and no pointer state SHALL exist.

Structure
REQ-024 A shared package wb_pkg SHALL hold the requester-id enum (WB_ALU, WB_LD) and the default DATA_WIDTH/ADR_WIDTH constants.
REQ-025 The holding buffer SHALL be one sub-module, wb_hold_buf, instantiated once per requester.

Verification
REQ-026 Single ALU write addr=5, data=0xDEADBEEF -> we3=1, a3=5, wd3=0xDEADBEEF exactly 2 cycles after handshake, for one cycle.
REQ-027 ALU and ld valid in the same cycle, addr 3/4 -> fixed priority: a3=4 then a3=3 on consecutive cycles; RR: alternation over repeated contests.
REQ-028 ld write addr=0, data=0x1234 -> ld_ready=1, we3 stays 0, busy stays 0.
REQ-029 Both requesters streaming continuously for 10 cycles (fixed priority) -> ld sees 10 writes, alu_ready stays 0 after its buffer fills, and alu data is held stable.
REQ-030 Same address 7 from alu (0xA) and ld (0xB) together -> writes 0xB then 0xA under fixed priority; final value 0xA.
REQ-031 rst asserted with both buffers full -> next cycle we3=0, busy=0, both ready=1 after release, and no stale write issued.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the register-file writeback arbiter.
//   - WB_DATA_WIDTH / WB_ADR_WIDTH : default widths of write data and address
//   - wb_req_e                     : requester identity (ALU or load unit)
//   - wb_other()                   : returns the opposite requester id
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADR_WIDTH  = 5;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LD  = 1'b1
    } wb_req_e;

    function automatic wb_req_e wb_other(input wb_req_e id);
        return (id == WB_ALU) ? WB_LD : WB_ALU;
    endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// -----------------------------------------------------------------------------
// wb_hold_buf
// One-entry holding buffer for a single writeback requester.
//
// Handshake: a transfer happens on a cycle where valid_i and ready_o are both
// high. ready_o is high when the entry is empty, or when it is full and being
// granted this cycle (drain and refill at the same edge). ready_o is forced low
// while rst_i is high. A transfer to address 0 is accepted but never stored.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i, ready_o    : requester handshake
//   addr_i, data_i      : requester write address / data
//   grant_i             : arbiter drains the entry at the next edge
//   full_o              : entry holds a pending write
//   addr_o, data_o      : stored write address / data
// -----------------------------------------------------------------------------
module wb_hold_buf
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADR_WIDTH  = WB_ADR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADR_WIDTH-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  grant_i,
    output logic                  full_o,
    output logic [ADR_WIDTH-1:0]  addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  full_q, full_d;
    logic [ADR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  accept;
    logic                  store;

    assign ready_o = ~rst_i & (~full_q | grant_i);
    assign accept  = valid_i & ready_o;
    // Writes to register 0 are swallowed here so they never reach the port.
    assign store   = accept & (addr_i != '0);

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (grant_i) begin
            full_d = 1'b0;
        end
        // Contents only change on a store, and a store is only possible when
        // the entry is empty or leaving this cycle, so held data stays stable.
        if (store) begin
            full_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges ALU and load-unit writebacks onto the single register-file write port.
// Each requester has a one-entry holding buffer; at most one full buffer is
// granted per cycle and the grant loads the registered write port at the next
// edge (minimum two cycles from handshake to we3).
//
// Arbitration: fixed priority, load unit over ALU. When macro WB_RR_ARB_EN is
// defined, arbitration becomes round-robin: a contested grant hands priority to
// the other requester; uncontested grants leave the pointer alone.
//
// Ports
//   clk, rst                          : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_addr/alu_data : ALU writeback requester
//   ld_valid/ld_ready/ld_addr/ld_data     : load-unit writeback requester
//   we3, a3, wd3                      : registered register-file write port
//   busy                              : a buffered entry or a write is pending
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADR_WIDTH  = WB_ADR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADR_WIDTH-1:0]  alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,

    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADR_WIDTH-1:0]  ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,

    output logic                  we3,
    output logic [ADR_WIDTH-1:0]  a3,
    output logic [DATA_WIDTH-1:0] wd3,

    output logic                  busy
);

    logic                  alu_full, ld_full;
    logic [ADR_WIDTH-1:0]  alu_baddr, ld_baddr;
    logic [DATA_WIDTH-1:0] alu_bdata, ld_bdata;
    logic                  grant_alu, grant_ld;

    logic                  we3_q, we3_d;
    logic [ADR_WIDTH-1:0]  a3_q, a3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

    wb_hold_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADR_WIDTH  (ADR_WIDTH)
    ) u_alu_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (alu_valid),
        .ready_o (alu_ready),
        .addr_i  (alu_addr),
        .data_i  (alu_data),
        .grant_i (grant_alu),
        .full_o  (alu_full),
        .addr_o  (alu_baddr),
        .data_o  (alu_bdata)
    );

    wb_hold_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADR_WIDTH  (ADR_WIDTH)
    ) u_ld_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (ld_valid),
        .ready_o (ld_ready),
        .addr_i  (ld_addr),
        .data_i  (ld_data),
        .grant_i (grant_ld),
        .full_o  (ld_full),
        .addr_o  (ld_baddr),
        .data_o  (ld_bdata)
    );

`ifdef WB_RR_ARB_EN
    // ptr_q names the requester that wins the next contest.
    wb_req_e ptr_q, ptr_d;
    logic    contested;

    assign contested = alu_full & ld_full;

    always_comb begin
        grant_ld  = ld_full  & (~alu_full | (ptr_q == WB_LD));
        grant_alu = alu_full & (~ld_full  | (ptr_q == WB_ALU));
        ptr_d     = ptr_q;
        if (contested) begin
            ptr_d = wb_other(ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= WB_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_ld  = ld_full;
        grant_alu = alu_full & ~ld_full;
    end
`endif

    // Write port: a3/wd3 only move on a grant, so they hold when idle.
    always_comb begin
        we3_d = grant_ld | grant_alu;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (grant_ld) begin
            a3_d  = ld_baddr;
            wd3_d = ld_bdata;
        end else if (grant_alu) begin
            a3_d  = alu_baddr;
            wd3_d = alu_bdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    assign we3  = we3_q;
    assign a3   = a3_q;
    assign wd3  = wd3_q;
    assign busy = alu_full | ld_full | we3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, ld_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_addr, ld_addr;
    logic [31:0] alu_data, ld_data;
    logic        we3, busy;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int n_pass  = 0;
    int n_total = 0;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ldd;
        logic        e_ar;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic        e_busy;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                                input logic e_ar, input logic e_lr, input logic e_we,
                                input logic [4:0] e_a3, input logic [31:0] e_wd, input logic e_busy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ldd = ldd;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we;
        v.e_a3 = e_a3; v.e_wd = e_wd; v.e_busy = e_busy;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ldd);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Both requesters present one write in the same cycle; check stall
    // readiness, then the two writes in the expected grant order.
    task automatic run_contest(input string tag,
                               input logic [4:0] aa, input logic [31:0] ad,
                               input logic [4:0] la, input logic [31:0] ldd,
                               input logic e_ar, input logic e_lr,
                               input logic [4:0] f_a, input logic [31:0] f_d,
                               input logic [4:0] s_a, input logic [31:0] s_d);
        drive(1'b1, aa, ad, 1'b1, la, ldd);
        @(negedge clk);
        check({tag, ".hs_ar"}, alu_ready, 1'b1);
        check({tag, ".hs_lr"}, ld_ready, 1'b1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        check({tag, ".stall_ar"}, alu_ready, e_ar);
        check({tag, ".stall_lr"}, ld_ready, e_lr);
        check({tag, ".stall_we3"}, we3, 1'b0);
        next_cycle();
        @(negedge clk);
        check({tag, ".w1_we3"}, we3, 1'b1);
        check({tag, ".w1_a3"}, a3, f_a);
        check({tag, ".w1_wd3"}, wd3, f_d);
        next_cycle();
        @(negedge clk);
        check({tag, ".w2_we3"}, we3, 1'b1);
        check({tag, ".w2_a3"}, a3, s_a);
        check({tag, ".final_wd3"}, wd3, s_d);
        next_cycle();
        @(negedge clk);
        check({tag, ".idle_we3"}, we3, 1'b0);
        check({tag, ".idle_busy"}, busy, 1'b0);
        next_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ld_cnt;
        int alu_cnt;
        int alu_cyc;

        vecs[0]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 0,  32'h0,        0);
        vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 1, 0, 0,  32'h0,        0);
        vecs[2]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 0,  32'h0,        1);
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 5,  32'hDEADBEEF, 1);
        vecs[4]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 5,  32'hDEADBEEF, 0);
        vecs[5]  = mk(0, 0, 0,            1, 0, 32'h1234, 1, 1, 0, 5, 32'hDEADBEEF, 0);
        vecs[6]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 5,  32'hDEADBEEF, 0);
        vecs[7]  = mk(0, 0, 0,            1, 9, 32'h55, 1, 1, 0, 5,  32'hDEADBEEF, 0);
        vecs[8]  = mk(1, 10, 32'h66,      0, 0, 0,      1, 1, 0, 5,  32'hDEADBEEF, 1);
        vecs[9]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 9,  32'h55,       1);
        vecs[10] = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 10, 32'h66,       1);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 10, 32'h66,       0);
        vecs[12] = mk(1, 1, 32'h1,        0, 0, 0,      1, 1, 0, 10, 32'h66,       0);
        vecs[13] = mk(1, 2, 32'h2,        0, 0, 0,      1, 1, 0, 10, 32'h66,       1);
        vecs[14] = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 1,  32'h1,        1);
        vecs[15] = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 2,  32'h2,        1);
        vecs[16] = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 2,  32'h2,        0);
        vecs[17] = mk(1, 0, 32'hFFFF,     0, 0, 0,      1, 1, 0, 2,  32'h2,        0);
        vecs[18] = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 2,  32'h2,        0);

        // ---- reset ----
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst.alu_ready", alu_ready, 1'b0);
        check("rst.ld_ready", ld_ready, 1'b0);
        check("rst.we3", we3, 1'b0);
        check("rst.a3", a3, 5'd0);
        check("rst.wd3", wd3, 32'h0);
        check("rst.busy", busy, 1'b0);
        next_cycle();
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ldd);
            @(negedge clk);
            check($sformatf("row%0d.alu_ready", i), alu_ready, vecs[i].e_ar);
            check($sformatf("row%0d.ld_ready", i), ld_ready, vecs[i].e_lr);
            check($sformatf("row%0d.we3", i), we3, vecs[i].e_we);
            check($sformatf("row%0d.a3", i), a3, vecs[i].e_a3);
            check($sformatf("row%0d.wd3", i), wd3, vecs[i].e_wd);
            check($sformatf("row%0d.busy", i), busy, vecs[i].e_busy);
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // ---- contests and same-address pair ----
`ifdef WB_RR_ARB_EN
        run_contest("rr_c1", 3, 32'h33, 4, 32'h44, 1'b1, 1'b0, 3, 32'h33, 4, 32'h44);
        run_contest("rr_c2", 3, 32'h33, 4, 32'h44, 1'b0, 1'b1, 4, 32'h44, 3, 32'h33);
        run_contest("rr_same", 7, 32'hA, 7, 32'hB, 1'b1, 1'b0, 7, 32'hA, 7, 32'hB);
`else
        run_contest("fp_c1", 3, 32'h33, 4, 32'h44, 1'b0, 1'b1, 4, 32'h44, 3, 32'h33);
        run_contest("fp_c2", 3, 32'h33, 4, 32'h44, 1'b0, 1'b1, 4, 32'h44, 3, 32'h33);
        run_contest("fp_same", 7, 32'hA, 7, 32'hB, 1'b0, 1'b1, 7, 32'hB, 7, 32'hA);

        // ---- both requesters streaming for 10 cycles ----
        ld_cnt  = 0;
        alu_cnt = 0;
        alu_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            if (c < 10) drive(1'b1, 5'd12, 32'h200 + c, 1'b1, 5'd8, 32'h100 + c);
            else        drive(1'b0, '0, '0, 1'b0, '0, '0);
            @(negedge clk);
            if (c >= 1 && c < 10) check($sformatf("stream%0d.alu_ready", c), alu_ready, 1'b0);
            if (c < 10)           check($sformatf("stream%0d.ld_ready", c), ld_ready, 1'b1);
            if (we3) begin
                if (a3 == 5'd8) begin
                    check($sformatf("stream.ld_wd3_%0d", ld_cnt), wd3, 32'h100 + ld_cnt);
                    ld_cnt++;
                end else begin
                    check("stream.alu_a3", a3, 5'd12);
                    check("stream.alu_held_wd3", wd3, 32'h200);
                    alu_cnt++;
                    alu_cyc = c;
                end
            end
            next_cycle();
        end
        check("stream.ld_writes", ld_cnt, 10);
        check("stream.alu_writes", alu_cnt, 1);
        check("stream.alu_write_cycle", alu_cyc, 12);
        @(negedge clk);
        check("stream.end_busy", busy, 1'b0);
        next_cycle();
`endif

        // ---- reset with both buffers full ----
        drive(1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check("rstfull.busy_before", busy, 1'b1);
        check("rstfull.alu_ready_in_rst", alu_ready, 1'b0);
        check("rstfull.ld_ready_in_rst", ld_ready, 1'b0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstfull.we3", we3, 1'b0);
        check("rstfull.busy", busy, 1'b0);
        check("rstfull.alu_ready", alu_ready, 1'b1);
        check("rstfull.ld_ready", ld_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("rstfull.no_stale_we3_%0d", k), we3, 1'b0);
            check($sformatf("rstfull.no_stale_busy_%0d", k), busy, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
